// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_pkg: shared widths, sample type and bank-state encoding for the  |
// | 8-point FFT input buffer.                                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fft_pkg;

  localparam int DATA_W   = 25;
  localparam int N_POINTS = 8;
  localparam int CPLX_W   = 2 * DATA_W;

  typedef logic [CPLX_W-1:0] cplx_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_input_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_input_buffer_if: sample stream in, parallel frame out.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface fft_input_buffer_if #(
  parameter int DATA_W   = fft_pkg::DATA_W,
  parameter int N_POINTS = fft_pkg::N_POINTS
);

  logic [2*DATA_W-1:0]                 in_data_i;
  logic                                in_valid_i;
  logic                                in_sop_i;
  logic                                in_ready_o;
  logic [N_POINTS-1:0][2*DATA_W-1:0]   frame_o;
  logic                                frame_valid_o;
  logic                                frame_ready_i;
  logic                                sop_err_o;
  logic [7:0]                          drop_cnt_o;

  modport master (
    output in_data_i, in_valid_i, in_sop_i, frame_ready_i,
    input  in_ready_o, frame_o, frame_valid_o, sop_err_o, drop_cnt_o
  );

  modport slave (
    input  in_data_i, in_valid_i, in_sop_i, frame_ready_i,
    output in_ready_o, frame_o, frame_valid_o, sop_err_o, drop_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/fft_frame_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_frame_bank: one frame of sample registers, indexed write port    |
// | and full-width parallel read port.                                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fft_frame_bank import fft_pkg::*; #(
  parameter int ENTRIES = N_POINTS,
  parameter int WIDTH   = CPLX_W
) (
  input  wire                              clk_i,
  input  wire                              rst_i,
  input  wire                              i_we,
  input  wire [$clog2(ENTRIES)-1:0]        i_idx,
  input  wire [WIDTH-1:0]                  i_data,
  output logic [ENTRIES-1:0][WIDTH-1:0]    o_frame
);

  logic [ENTRIES-1:0][WIDTH-1:0] r_mem;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mem <= '0;
    end else if (i_we) begin
      r_mem[i_idx] <= i_data;
    end
  end

  assign o_frame = r_mem;

endmodule
`default_nettype wire

// File: rtl/fft_input_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_input_buffer: serial-to-parallel ping-pong frame assembler for   |
// | the 8-point FFT, with SOP resynchronisation and drop counting.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fft_input_buffer import fft_pkg::*; #(
  parameter int DATA_W   = fft_pkg::DATA_W,
  parameter int N_POINTS = fft_pkg::N_POINTS
) (
  input  wire               clk_i,
  input  wire               rst_i,
  fft_input_buffer_if.slave bus
);

  localparam int c_IDX_W  = $clog2(N_POINTS);
  localparam int c_CPLX_W = 2 * DATA_W;

  if (N_POINTS != 8) begin : g_bad_n_points
    $error("fft_input_buffer: N_POINTS must be 8");
  end

  bank_state_t                          r_state [2];
  logic                                 r_wr_bank;
  logic                                 r_rd_bank;
  logic [c_IDX_W-1:0]                   r_wr_idx;
  logic                                 r_sop_err;
  logic [7:0]                           r_drop_cnt;

  logic [N_POINTS-1:0][c_CPLX_W-1:0]    w_frame [2];
  logic                                 w_ready;
  logic                                 w_fvalid;
  logic                                 w_acc;
  logic                                 w_rel;
  logic                                 w_sop_err;
  logic                                 w_last;
  logic [c_IDX_W-1:0]                   w_wr_idx;

  // Ready is gated by reset so it reads 0 for the whole time rst_i is low.
  assign w_ready   = rst_i && (r_state[r_wr_bank] != FULL);
  assign w_fvalid  = (r_state[r_rd_bank] == FULL);
  assign w_acc     = bus.in_valid_i && w_ready;
  assign w_rel     = w_fvalid && bus.frame_ready_i;
  assign w_sop_err = w_acc && bus.in_sop_i && (r_wr_idx != '0);
  assign w_wr_idx  = w_sop_err ? '0 : r_wr_idx;
  assign w_last    = w_acc && (w_wr_idx == c_IDX_W'(N_POINTS - 1));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(
      .ENTRIES (N_POINTS),
      .WIDTH   (c_CPLX_W)
    ) u_bank (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_we    (w_acc && (r_wr_bank == 1'(b))),
      .i_idx   (w_wr_idx),
      .i_data  (bus.in_data_i),
      .o_frame (w_frame[b])
    );
  end

  // Release and fill always target different banks: the write bank is
  // never FULL when accepting, the read bank is FULL when releasing.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state[0] <= EMPTY;
      r_state[1] <= EMPTY;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_idx   <= '0;
      r_sop_err  <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      if (w_rel) begin
        r_state[r_rd_bank] <= EMPTY;
        r_rd_bank          <= ~r_rd_bank;
      end
      if (w_acc) begin
        r_state[r_wr_bank] <= w_last ? FULL : FILLING;
        r_wr_idx           <= w_last ? '0 : w_wr_idx + c_IDX_W'(1);
        if (w_last) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end
      r_sop_err <= w_sop_err;
      if (w_sop_err && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign bus.in_ready_o    = w_ready;
  assign bus.frame_valid_o = w_fvalid;
  assign bus.frame_o       = w_frame[r_rd_bank];
  assign bus.sop_err_o     = r_sop_err;
  assign bus.drop_cnt_o    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fft_input_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fft_input_buffer: directed + random stimulus against a queue-based|
// | model of frame assembly, release, SOP discard and drop counting.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fft_input_buffer;
  import fft_pkg::*;

  typedef logic [N_POINTS-1:0][CPLX_W-1:0] frame_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_input_buffer_if #(.DATA_W(DATA_W), .N_POINTS(N_POINTS)) bus ();

  fft_input_buffer #(.DATA_W(DATA_W), .N_POINTS(N_POINTS)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  int         n_vec = 0;
  int         n_bad = 0;
  frame_t     m_full[$];
  cplx_t      m_cur[$];
  logic [7:0] m_drop = 8'd0;
  logic       m_err  = 1'b0;

  task automatic chk(input string tag, input logic [N_POINTS*CPLX_W-1:0] obs,
                     input logic [N_POINTS*CPLX_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cplx_t rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[CPLX_W-1:0];
  endfunction

  task automatic model_reset();
    m_full.delete();
    m_cur.delete();
    m_drop = 8'd0;
    m_err  = 1'b0;
  endtask

  task automatic check_outputs();
    chk("in_ready", bus.in_ready_o, (m_full.size() < 2));
    chk("frame_valid", bus.frame_valid_o, (m_full.size() > 0));
    if (m_full.size() > 0) chk("frame", bus.frame_o, m_full[0]);
    chk("sop_err", bus.sop_err_o, m_err);
    chk("drop_cnt", bus.drop_cnt_o, m_drop);
  endtask

  // One clock: drive on the falling edge, check, then advance the model.
  task automatic cycle(input logic v, input logic s, input cplx_t d, input logic fr);
    bit     acc, rel;
    frame_t f;
    @(negedge clk);
    bus.in_valid_i    = v;
    bus.in_sop_i      = s;
    bus.in_data_i     = d;
    bus.frame_ready_i = fr;
    check_outputs();
    acc = v && (m_full.size() < 2);
    rel = fr && (m_full.size() > 0);
    @(posedge clk);
    m_err = 1'b0;
    if (rel) void'(m_full.pop_front());
    if (acc) begin
      if (s && m_cur.size() != 0) begin
        m_cur.delete();
        m_err = 1'b1;
        if (m_drop != 8'd255) m_drop++;
      end
      m_cur.push_back(d);
      if (m_cur.size() == N_POINTS) begin
        for (int k = 0; k < N_POINTS; k++) f[k] = m_cur[k];
        m_full.push_back(f);
        m_cur.delete();
      end
    end
  endtask

  task automatic drain();
    repeat (3) cycle(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.in_sop_i   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_frame_valid", bus.frame_valid_o, 1'b0);
    chk("rst_in_ready", bus.in_ready_o, 1'b0);
    chk("rst_sop_err", bus.sop_err_o, 1'b0);
    chk("rst_drop_cnt", bus.drop_cnt_o, 8'd0);
    chk("rst_frame", bus.frame_o, '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", bus.in_ready_o, 1'b1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cplx_t d;
    int    acc_n;
    bit    r;
    bus.in_valid_i    = 1'b0;
    bus.in_sop_i      = 1'b0;
    bus.in_data_i     = '0;
    bus.frame_ready_i = 1'b0;
    do_reset();

    // Back-to-back, consumer always ready.
    for (int i = 1; i <= 16; i++) cycle(1'b1, (i == 1 || i == 9), CPLX_W'(i), 1'b1);
    drain();

    // Consumer stalled: two banks fill, then one handshake frees one.
    acc_n = 0;
    for (int i = 0; i < 24; i++) begin
      r = (m_full.size() < 2);
      cycle(1'b1, 1'b0, CPLX_W'(1 + acc_n), 1'b0);
      if (r) acc_n++;
    end
    #1 chk("stall_ready", bus.in_ready_o, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0);
    #1 chk("stall_frame2_lane0", bus.frame_o[0], CPLX_W'(9));
    drain();

    // SOP mid-frame discards the first five samples.
    for (int i = 0; i < 5; i++) cycle(1'b1, (i == 0), rnd(), 1'b1);
    cycle(1'b1, 1'b1, CPLX_W'(50'h100), 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, rnd(), 1'b1);
    #1 chk("sop_lane0", bus.frame_o[0], CPLX_W'(50'h100));
    drain();
    #1 chk("drop_after_sop", bus.drop_cnt_o, 8'd1);

    // Continuous SOP: every sample after the first is a discard.
    for (int i = 0; i < 301; i++) cycle(1'b1, 1'b1, rnd(), 1'b1);
    #1 chk("drop_saturated", bus.drop_cnt_o, 8'd255);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, rnd(), 1'b1);
    drain();

    // Reset with one full bank pending and a partial frame.
    for (int i = 0; i < 11; i++) cycle(1'b1, (i == 0 || i == 8), rnd(), 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, (i == 0), rnd(), 1'b0);
    #1 chk("post_rst_valid", bus.frame_valid_o, 1'b1);
    drain();

    // Extreme component values pass untouched.
    d = {25'h1000000, 25'h0FFFFFF};
    cycle(1'b1, 1'b1, d, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, rnd(), 1'b0);
    #1;
    chk("ext_lane0", bus.frame_o[0], d);
    chk("ext_re_sign", bus.frame_o[0][CPLX_W-1], 1'b1);
    chk("ext_im_sign", bus.frame_o[0][DATA_W-1], 1'b0);
    drain();

    // Random traffic with occasional SOP and back-pressure.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), rnd(),
            ($urandom_range(0, 2) != 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
